// File: rtl/alu_pkg.sv
// Shared types for seq_alu: op encodings, FSM states and the flag bundle.
// BUSY only exists when SEQ_ALU_MUL_EN is defined.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } alu_state_t;
`endif

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA with the last shifted-out bit.
// An extra guard bit beside the operand catches the shifted-out bit; it is 0 for s = 0.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   s,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] sll, srl, sra;

    always_comb begin
        sll = {1'b0, a} << s;
        srl = {a, 1'b0} >> s;
        sra = $signed({a, 1'b0}) >>> s;
        res   = sll[WIDTH-1:0];
        carry = sll[WIDTH];
        case (op)
            OP_SRL:  {res, carry} = srl;
            OP_SRA:  {res, carry} = sra;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked registered ALU with an optional iterative shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise op 111 passes a through.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag
);

    alu_state_t       state, state_nxt, accept_st;
    alu_op_t          opc;
    logic             accept, is_mul;
    logic [WIDTH-1:0] b_eff, sh_res, sc_res, res_q;
    logic [WIDTH:0]   sum;
    logic             sh_carry;
    alu_flags_t       sc_flags, flags_q;

    assign opc = alu_op_t'(op);

    alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .op    (opc),
        .a     (a),
        .s     (b[SHW-1:0]),
        .res   (sh_res),
        .carry (sh_carry)
    );

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        b_eff    = (opc == OP_SUB) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (opc == OP_SUB) ? 1'b1 : cin};
        sc_res   = a;
        sc_flags = '0;
        case (opc)
            OP_ADD, OP_SUB: begin
                sc_res         = sum[WIDTH-1:0];
                sc_flags.carry = sum[WIDTH];
                sc_flags.ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_res = a & b;
            OP_XOR: sc_res = a ^ b;
            OP_SLL, OP_SRL, OP_SRA: begin
                sc_res         = sh_res;
                sc_flags.carry = sh_carry;
            end
            default: ;
        endcase
        sc_flags.zero = (sc_res == '0);
        sc_flags.neg  = sc_res[WIDTH-1];
    end

`ifdef SEQ_ALU_MUL_EN
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    alu_flags_t         mul_flags;

    assign is_mul    = (opc == OP_MUL);
    assign accept_st = is_mul ? ST_BUSY : ST_DONE;

    always_comb begin
        acc_nxt         = acc + (mplier[0] ? mcand : '0);
        mul_flags.carry = |acc_nxt[2*WIDTH-1:WIDTH];
        mul_flags.ovf   = |acc_nxt[2*WIDTH-1:WIDTH];
        mul_flags.zero  = (acc_nxt[WIDTH-1:0] == '0);
        mul_flags.neg   = acc_nxt[WIDTH-1];
    end

    // One multiplier bit per BUSY cycle; cnt wraps to 0 after WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept && is_mul) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (state == ST_BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign accept_st = ST_DONE;
`endif

    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
        accept    = in_valid && in_ready;
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = accept_st;
            ST_DONE: if (out_ready) state_nxt = accept ? accept_st : ST_IDLE;
`ifdef SEQ_ALU_MUL_EN
            ST_BUSY: if (cnt == SHW'(WIDTH-1)) state_nxt = ST_DONE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                res_q   <= sc_res;
                flags_q <= sc_flags;
            end
`ifdef SEQ_ALU_MUL_EN
            else if (state == ST_BUSY && cnt == SHW'(WIDTH-1)) begin
                res_q   <= acc_nxt[WIDTH-1:0];
                flags_q <= mul_flags;
            end
`endif
        end
    end

    assign out_valid  = (state == ST_DONE);
    assign res        = res_q;
    assign carry_flag = flags_q.carry;
    assign zero_flag  = flags_q.zero;
    assign neg_flag   = flags_q.neg;
    assign ovf_flag   = flags_q.ovf;

endmodule
